// File: rtl/pixel_merge_fifo.sv
// pixel_merge_fifo: merges pixel results from NUM_ENGINES writers into one
// ordered first-word-fall-through stream.
//   clk, reset   : clock and synchronous active-high reset
//   wr_data      : NUM_ENGINES packed entries, channel i at [DATA_WIDTH*i +: DATA_WIDTH]
//   wr_valid     : per-channel offer
//   wr_ready     : per-channel grant, derived only from level and rr_ptr
//   rd_data      : registered head entry
//   rd_valid     : registered head-present flag
//   rd_ready     : consumer accepts head
//   level        : entries held, head included
//   almost_full  : registered, level >= DEPTH - AF_MARGIN
module pixel_merge_fifo #(
    parameter int unsigned DATA_WIDTH  = 20,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned NUM_ENGINES = 5,
    parameter int unsigned AF_MARGIN   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH*NUM_ENGINES-1:0] wr_data,
    input  logic [NUM_ENGINES-1:0]            wr_valid,
    output logic [NUM_ENGINES-1:0]            wr_ready,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]        level,
    output logic                              almost_full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned RW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int unsigned CW = $clog2(NUM_ENGINES + 1);

    // Elaboration-time parameter legality
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < NUM_ENGINES) begin : g_depth_check
        $error("pixel_merge_fifo: DEPTH must be a power of two and >= NUM_ENGINES");
    end
    if (NUM_ENGINES < 1 || NUM_ENGINES > 16) begin : g_engine_check
        $error("pixel_merge_fifo: NUM_ENGINES must be in 1..16");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [RW-1:0]         rr_ptr;

    logic [LW-1:0]         free_c;
    logic [RW-1:0]         rot_idx   [NUM_ENGINES];
    logic                  slot_en   [NUM_ENGINES];
    logic [AW-1:0]         slot_addr [NUM_ENGINES];
    logic [DATA_WIDTH-1:0] slot_data [NUM_ENGINES];
    logic [CW-1:0]         acc_cnt;
    logic                  pop_c;
    logic [LW-1:0]         level_nxt;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [AW-1:0]         wr_ptr_nxt;
    logic [RW-1:0]         rr_nxt;
    logic [DATA_WIDTH-1:0] head_nxt;

    // Space available this cycle; a same-cycle pop does not add to it
    assign free_c = LW'(DEPTH) - level;

    // Channel served at each rotation position, starting at rr_ptr
    always_comb begin
        int unsigned sum;
        sum = 0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NUM_ENGINES) begin
                sum = sum - NUM_ENGINES;
            end
            rot_idx[k] = RW'(sum);
        end
    end

    // Grants: everyone when space suffices, else the first free channels in rotation
    always_comb begin
        wr_ready = '0;
        if (32'(free_c) >= NUM_ENGINES) begin
            wr_ready = '1;
        end else begin
            for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
                if (k < 32'(free_c)) begin
                    wr_ready[rot_idx[k]] = 1'b1;
                end
            end
        end
    end

    // Pack accepted entries into consecutive slots in rotation order
    always_comb begin
        acc_cnt = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            slot_en[k]   = wr_valid[rot_idx[k]] & wr_ready[rot_idx[k]];
            slot_addr[k] = wr_ptr + AW'(acc_cnt);
            slot_data[k] = wr_data[DATA_WIDTH*32'(rot_idx[k]) +: DATA_WIDTH];
            if (slot_en[k]) begin
                acc_cnt = acc_cnt + CW'(1);
            end
        end
    end

    assign pop_c      = rd_valid & rd_ready;
    assign level_nxt  = level + LW'(acc_cnt) - LW'(pop_c);
    assign rd_ptr_nxt = rd_ptr + AW'(pop_c);
    assign wr_ptr_nxt = wr_ptr + AW'(acc_cnt);

    // Rotation advances past the channels that were offered a slot when space was short
    always_comb begin
        int unsigned sum;
        sum    = 32'(rr_ptr) + 32'(free_c);
        rr_nxt = rr_ptr;
        if (free_c != '0 && 32'(free_c) < NUM_ENGINES) begin
            if (sum >= NUM_ENGINES) begin
                sum = sum - NUM_ENGINES;
            end
            rr_nxt = RW'(sum);
        end
    end

    // Next head: bypass from this cycle's writes when the head slot is being filled now
    always_comb begin
        head_nxt = mem[rd_ptr_nxt];
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            if (slot_en[k] && slot_addr[k] == rd_ptr_nxt) begin
                head_nxt = slot_data[k];
            end
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
                if (slot_en[k]) begin
                    mem[slot_addr[k]] <= slot_data[k];
                end
            end
        end
    end

    // Pointers, occupancy and registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rr_ptr      <= '0;
            level       <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            rr_ptr      <= rr_nxt;
            level       <= level_nxt;
            rd_valid    <= (level_nxt != '0);
            if (level_nxt != '0) begin
                rd_data <= head_nxt;
            end
            almost_full <= (32'(level_nxt) + AF_MARGIN >= DEPTH);
        end
    end

endmodule
